// File: rtl/alu_flag_writeback_if.sv
// alu_flag_writeback_if
//   Bundles every non-clock signal of alu_flag_writeback.
//   master : upstream adder, downstream consumer, branch unit (drives in_*, out_ready, cc_*)
//   slave  : alu_flag_writeback itself
//   Signals:
//     in_valid/in_ready/in_z/in_{s,zr,c,p,o}/in_fmask : adder result handshake + flags + write mask
//     out_valid/out_ready/out_z                        : result FIFO head handshake
//     flags, o_sticky, clr_sticky                      : architectural flags, sticky overflow
//     cc_req/cc_code/cc_ack/cc_true                    : condition-code evaluation
interface alu_flag_writeback_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_z;
    logic             in_s;
    logic             in_zr;
    logic             in_c;
    logic             in_p;
    logic             in_o;
    logic [4:0]       in_fmask;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_z;
    logic [4:0]       flags;
    logic             o_sticky;
    logic             clr_sticky;
    logic             cc_req;
    logic [3:0]       cc_code;
    logic             cc_ack;
    logic             cc_true;

    modport master (
        output in_valid, in_z, in_s, in_zr, in_c, in_p, in_o, in_fmask,
        output out_ready, clr_sticky, cc_req, cc_code,
        input  in_ready, out_valid, out_z, flags, o_sticky, cc_ack, cc_true
    );

    modport slave (
        input  in_valid, in_z, in_s, in_zr, in_c, in_p, in_o, in_fmask,
        input  out_ready, clr_sticky, cc_req, cc_code,
        output in_ready, out_valid, out_z, flags, o_sticky, cc_ack, cc_true
    );
endinterface

// File: rtl/alu_flag_writeback.sv
// alu_flag_writeback
//   Write-back stage behind the 64-bit adder. Accepted sums go into an in-order
//   DEPTH-entry FIFO feeding the register-file write port; the adder flags are
//   merged into the architectural flags register under a per-op write mask, and
//   x86-style condition codes are evaluated for the branch unit.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset
//     bus   : alu_flag_writeback_if.slave (handshakes, flags, condition codes)
//   Flag bit order everywhere is {O,S,ZR,P,C}.
module alu_flag_writeback #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_flag_writeback_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // flag bit positions
    localparam int F_C  = 0;
    localparam int F_P  = 1;
    localparam int F_ZR = 2;
    localparam int F_S  = 3;
    localparam int F_O  = 4;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [4:0]       r_flags;
    logic             r_sticky;
    logic             r_cc_ack;
    logic             r_cc_true;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_pop;
    logic [4:0]       w_new_flags;
    logic [4:0]       w_flags_next;

    // Condition selector: code[3:1] picks the base predicate, code[0] inverts it.
    function automatic logic f_cond(input logic [3:0] code, input logic [4:0] f);
        logic base;
        logic sxo;
        sxo  = f[F_S] ^ f[F_O];
        base = 1'b0;
        case (code[3:1])
            3'd0: base = f[F_O];
            3'd1: base = f[F_C];
            3'd2: base = f[F_ZR];
            3'd3: base = f[F_C] | f[F_ZR];
            3'd4: base = f[F_S];
            3'd5: base = f[F_P];
            3'd6: base = sxo;
            3'd7: base = f[F_ZR] | sxo;
            default: base = 1'b0;
        endcase
        return base ^ code[0];
    endfunction

    // Ready is a pure function of registered occupancy: no pass-through when full.
    assign w_in_ready  = (r_count != FULL);
    assign w_out_valid = (r_count != '0);
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    assign w_new_flags = {bus.in_o, bus.in_s, bus.in_zr, bus.in_p, bus.in_c};

    // The mux on w_accept keeps X on idle in_* lines out of the flags register.
    always_comb begin
        w_flags_next = r_flags;
        if (w_accept)
            w_flags_next = (r_flags & ~bus.in_fmask) | (w_new_flags & bus.in_fmask);
    end

    // Result FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= bus.in_z;
                r_wr_ptr        <= r_wr_ptr + 1'b1;   // DEPTH is a power of 2: natural wrap
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Flags and sticky overflow; a set on the same cycle as clr_sticky wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flags  <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_flags <= w_flags_next;
            if (w_accept & bus.in_o & bus.in_fmask[F_O])
                r_sticky <= 1'b1;
            else if (bus.clr_sticky)
                r_sticky <= 1'b0;
        end
    end

    // Condition evaluation uses w_flags_next so an accept in the request cycle is seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cc_ack  <= 1'b0;
            r_cc_true <= 1'b0;
        end else begin
            r_cc_ack <= bus.cc_req;
            if (bus.cc_req)
                r_cc_true <= f_cond(bus.cc_code, w_flags_next);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_z     = r_mem[r_rd_ptr];
    assign bus.flags     = r_flags;
    assign bus.o_sticky  = r_sticky;
    assign bus.cc_ack    = r_cc_ack;
    assign bus.cc_true   = r_cc_true;
endmodule
